instr_issue_ctrl: RTL

INSTR_ISSUE_CTRL -- requirements
Module: instr_issue_ctrl

---
 rtl/instr_issue_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/instr_issue_ctrl.sv
// instr_issue_ctrl: FIFO-fed instruction issuer with gap spacing and HALT opcode; define ISSUE_STATUS_EN for sticky status flags
module instr_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int ISSUE_GAP = 2
) (
  input  logic                     pad_clk,
  input  logic                     pad_rst,
  input  logic [19:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     resume,
  input  logic [2:0]               flag_in,
  output logic [19:0]              instr_out,
  output logic                     instr_valid,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   level,
  output logic [2:0]               status
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [3:0] GAP_LD = ISSUE_GAP == 0 ? 4'd0 : 4'(ISSUE_GAP - 1);
  typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;
  state_t state, state_nx;
  logic [19:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0] gap_cnt;
  logic push, pop, is_halt, issue;
  logic [19:0] head;
  assign in_ready = (level != FULL) && !flush;
  assign push = in_valid && in_ready;
  assign head = mem[rd_ptr];
  assign is_halt = head[19:16] == 4'hF;
  assign pop = (state == IDLE) && (level != '0);
  assign issue = pop && !is_halt;
  // state register
  always_ff @(posedge pad_clk)
    if (pad_rst) state <= IDLE;
    else state <= state_nx;
  // next-state logic; flush always returns to IDLE
  always_comb begin
    state_nx = flush ? IDLE :
               state == IDLE ? (pop ? (is_halt ? HALTED : (ISSUE_GAP == 0 ? IDLE : WAIT)) : IDLE) :
               state == WAIT ? (gap_cnt == 4'd0 ? IDLE : WAIT) :
               (resume ? IDLE : HALTED);
  end
  // state-decoded outputs
  always_comb begin
    halted = state == HALTED;
  end
  // FIFO storage, written only when a word is accepted
  always_ff @(posedge pad_clk)
    if (push) mem[wr_ptr] <= in_data;
  // pointers, occupancy, gap counter and issue register
  always_ff @(posedge pad_clk) begin
    if (pad_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      gap_cnt <= 4'd0;
      instr_out <= 20'h0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      gap_cnt <= 4'd0;
      instr_valid <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      gap_cnt <= issue ? GAP_LD : (state == WAIT && gap_cnt != 4'd0) ? gap_cnt - 4'd1 : gap_cnt;
      instr_valid <= issue;
      if (issue) instr_out <= head;
    end
  end
`ifdef ISSUE_STATUS_EN
  // sticky flags sampled the cycle after each issue
  always_ff @(posedge pad_clk)
    if (pad_rst || flush) status <= 3'b000;
    else if (instr_valid) status <= status | flag_in;
`else
  logic unused_flags;
  assign unused_flags = ^flag_in;
  assign status = 3'b000;
`endif
endmodule
